// File: rtl/accum_param_if.sv
// accum_param_if: control, operand and result bundle for accum_param.
//   master : drives clear/enable/load/mode/DataIn1/DataIn2, observes results
//   slave  : the accumulator; consumes the controls, drives Accum, GreyCode,
//            EvenParity, overflow, underflow and valid_out
// WIDTH must match the WIDTH of the accum_param instance it is bound to.
interface accum_param_if #(
  parameter int unsigned WIDTH = 8
);

  logic             clear;
  logic             enable;
  logic             load;
  logic [1:0]       mode;
  logic [WIDTH-1:0] DataIn1;
  logic [WIDTH-1:0] DataIn2;
  logic [WIDTH-1:0] Accum;
  logic [WIDTH-1:0] GreyCode;
  logic             EvenParity;
  logic             overflow;
  logic             underflow;
  logic             valid_out;

  modport master (
    output clear, enable, load, mode, DataIn1, DataIn2,
    input  Accum, GreyCode, EvenParity, overflow, underflow, valid_out
  );

  modport slave (
    input  clear, enable, load, mode, DataIn1, DataIn2,
    output Accum, GreyCode, EvenParity, overflow, underflow, valid_out
  );

endinterface

// File: rtl/accum_param.sv
// accum_param: parametrised running accumulator with four combine modes,
// a load path, sticky overflow/underflow flags and registered Gray-code and
// even-parity views of the running sum.
//
// Ports:
//   clock  : rising-edge system clock
//   reset  : asynchronous, active-low reset
//   bus    : accum_param_if.slave
//            clear      synchronous clear, wins over enable/load
//            enable     accept an update this cycle
//            load       with enable, Accum <= DataIn1 (mode ignored)
//            mode       00 +A, 01 +(A+B), 10 -A, 11 -(A+B)
//            DataIn1/2  operands A/B
//            Accum      running sum (registered)
//            GreyCode   Gray code of Accum (registered, coherent with Accum)
//            EvenParity XOR of all Accum bits (registered)
//            overflow   sticky, an add carried out of WIDTH bits
//            underflow  sticky, a subtract borrowed below zero
//            valid_out  high the cycle after an accepted update
//
// Optional feature: define ACCUM_SATURATE_EN to clamp Accum to all-ones on
// an overflowing add and to zero on an underflowing subtract instead of
// wrapping modulo 2^WIDTH. Flags behave identically in both builds.
module accum_param #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic         clock,
  input  logic         reset,
  accum_param_if.slave bus
);

  localparam int unsigned OP_W  = WIDTH + 1;  // A+B without truncation
  localparam int unsigned SUM_W = WIDTH + 2;  // Accum + (A+B) without truncation

  localparam logic [WIDTH-1:0] INIT_GRAY = INIT ^ (INIT >> 1);
  localparam logic             INIT_PAR  = ^INIT;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // result registers
  logic [WIDTH-1:0] accum_q;
  logic [WIDTH-1:0] gray_q;
  logic             par_q;
  logic             ovf_q;
  logic             unf_q;
  logic             valid_q;

  // next values for the result registers
  logic [WIDTH-1:0] accum_d;
  logic [WIDTH-1:0] gray_d;
  logic             par_d;
  logic             ovf_d;
  logic             unf_d;
  logic             valid_d;

  // datapath intermediates
  logic             update_c;
  logic             is_sub_c;
  logic [OP_W-1:0]  operand_c;
  logic [SUM_W-1:0] sum_c;
  logic [WIDTH-1:0] diff_c;
  logic             add_carry_c;
  logic             sub_borrow_c;
  logic             set_ovf_c;
  logic             set_unf_c;

  // An update is accepted only when enabled and not being cleared.
  assign update_c = bus.enable & ~bus.clear;
  assign is_sub_c = bus.mode[1];

  // Operand and both arithmetic results, evaluated every cycle at full width.
  always_comb begin
    operand_c    = {1'b0, bus.DataIn1}
                 + (bus.mode[0] ? {1'b0, bus.DataIn2} : OP_W'(0));
    sum_c        = {2'b00, accum_q} + {1'b0, operand_c};
    diff_c       = accum_q - operand_c[WIDTH-1:0];
    add_carry_c  = |sum_c[SUM_W-1:WIDTH];
    sub_borrow_c = ({1'b0, accum_q} < operand_c);
  end

  // Flag events raised by this cycle's update; loads never raise a flag.
  assign set_ovf_c = update_c & ~bus.load & ~is_sub_c & add_carry_c;
  assign set_unf_c = update_c & ~bus.load &  is_sub_c & sub_borrow_c;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: ERR is only left through clear or reset.
  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, RUN: begin
          if (set_ovf_c | set_unf_c) begin
            state_d = ERR;
          end else if (update_c) begin
            state_d = RUN;
          end
        end
        ERR:     state_d = ERR;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic: next Accum, then Gray/parity derived from that same value.
  always_comb begin
    accum_d = accum_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    valid_d = 1'b0;

    if (bus.clear) begin
      accum_d = INIT;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else if (bus.enable) begin
      valid_d = 1'b1;
      if (bus.load) begin
        accum_d = bus.DataIn1;
      end else if (!is_sub_c) begin
`ifdef ACCUM_SATURATE_EN
        accum_d = add_carry_c ? {WIDTH{1'b1}} : sum_c[WIDTH-1:0];
`else
        accum_d = sum_c[WIDTH-1:0];
`endif
      end else begin
`ifdef ACCUM_SATURATE_EN
        accum_d = sub_borrow_c ? {WIDTH{1'b0}} : diff_c;
`else
        accum_d = diff_c;
`endif
      end
      ovf_d = ovf_q | set_ovf_c;
      unf_d = unf_q | set_unf_c;
    end

    gray_d = accum_d ^ (accum_d >> 1);
    par_d  = ^accum_d;
  end

  // Result registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      accum_q <= INIT;
      gray_q  <= INIT_GRAY;
      par_q   <= INIT_PAR;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      accum_q <= accum_d;
      gray_q  <= gray_d;
      par_q   <= par_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      valid_q <= valid_d;
    end
  end

  assign bus.Accum      = accum_q;
  assign bus.GreyCode   = gray_q;
  assign bus.EvenParity = par_q;
  assign bus.overflow   = ovf_q;
  assign bus.underflow  = unf_q;
  assign bus.valid_out  = valid_q;

endmodule
